// File: rtl/countdown_pkg.sv
// Shared types and default constants for the seconds countdown engine.
package countdown_pkg;

    localparam int DEFAULT_CNT_W    = 8;
    localparam int DEFAULT_TICK_DIV = 100000000;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        PAUSE = 2'd2,
        DONE  = 2'd3
    } state_t;

endpackage

// File: rtl/countdown_tick_prescaler.sv
// Divides clk down to a one-cycle tick every TICK_DIV enabled cycles.
// The phase is held while en is low, so a paused second resumes where it stopped.
module tick_prescaler
    import countdown_pkg::*;
#(
    parameter int TICK_DIV = DEFAULT_TICK_DIV
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic clr,
    output logic tick
);

    localparam int            PW   = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PW-1:0] LAST = PW'(TICK_DIV - 1);

    logic [PW-1:0] phase;

    assign tick = en && (phase == LAST);

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            phase <= '0;
        end else if (en) begin
            phase <= tick ? '0 : phase + PW'(1);
        end
    end

endmodule

// File: rtl/countdown_core.sv
// Loadable seconds countdown with IDLE/RUN/PAUSE/DONE control around a 1 Hz tick.
// Define COUNTDOWN_AUTORELOAD_EN to reload the last preset on expiry instead of stopping.
module countdown_core
    import countdown_pkg::*;
#(
    parameter int CNT_W    = DEFAULT_CNT_W,
    parameter int TICK_DIV = DEFAULT_TICK_DIV
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [CNT_W-1:0] preset,
    input  logic             start,
    input  logic             pause,
    output logic [CNT_W-1:0] count,
    output logic             running,
    output logic             done,
    output logic             expired
);

    state_t           state;
    state_t           next_state;
    logic [CNT_W-1:0] next_count;
    logic             next_expired;
    logic [CNT_W-1:0] reload_value;
    logic             tick;
    logic             run_en;
    logic             at_one;

`ifdef COUNTDOWN_AUTORELOAD_EN
    localparam bit AUTORELOAD = 1'b1;

    always_ff @(posedge clk) begin
        if (rst) begin
            reload_value <= '0;
        end else if (load) begin
            reload_value <= preset;
        end
    end
`else
    localparam bit AUTORELOAD = 1'b0;

    assign reload_value = '0;
`endif

    assign run_en = (state == RUN);
    assign at_one = (count == CNT_W'(1));

    tick_prescaler #(
        .TICK_DIV(TICK_DIV)
    ) u_prescaler (
        .clk (clk),
        .rst (rst),
        .en  (run_en),
        .clr (load),
        .tick(tick)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // The final tick wins over a coincident pause unless autoreload keeps us running.
    always_comb begin
        next_state = state;
        if (load) begin
            next_state = IDLE;
        end else begin
            case (state)
                IDLE: begin
                    if (start && (count != '0)) begin
                        next_state = RUN;
                    end
                end
                RUN: begin
                    if (tick && at_one && !AUTORELOAD) begin
                        next_state = DONE;
                    end else if (pause) begin
                        next_state = PAUSE;
                    end
                end
                PAUSE: begin
                    if (start) begin
                        next_state = RUN;
                    end
                end
                DONE: begin
                    next_state = DONE;
                end
                default: begin
                    next_state = IDLE;
                end
            endcase
        end
    end

    always_comb begin
        next_count   = count;
        next_expired = 1'b0;
        if (load) begin
            next_count = preset;
        end else if (run_en && tick) begin
            if (at_one) begin
                next_expired = 1'b1;
                next_count   = AUTORELOAD ? reload_value : '0;
            end else begin
                next_count = count - CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count   <= '0;
            expired <= 1'b0;
        end else begin
            count   <= next_count;
            expired <= next_expired;
        end
    end

    always_comb begin
        running = (state == RUN);
        done    = (state == DONE);
    end

endmodule

// File: tb/tb_countdown_core.sv
// Scoreboard bench for countdown_core with TICK_DIV=4; follows COUNTDOWN_AUTORELOAD_EN if defined.
module tb_countdown_core;

    localparam int TB_DIV = 4;
    localparam int W      = 8;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         load = 1'b0;
    logic [W-1:0] preset = '0;
    logic         start = 1'b0;
    logic         pause = 1'b0;
    logic [W-1:0] count;
    logic         running;
    logic         done;
    logic         expired;

    typedef struct {
        int           cyc;
        logic [W-1:0] cnt;
        logic         exp;
        logic         run;
        logic         dn;
    } event_t;

    event_t       sb[$];
    int           cyc = 0;
    int           total = 0;
    int           bad = 0;
    bit           mon_en = 1'b0;
    logic [W-1:0] prev_count = '0;

    countdown_core #(
        .CNT_W   (W),
        .TICK_DIV(TB_DIV)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .load   (load),
        .preset (preset),
        .start  (start),
        .pause  (pause),
        .count  (count),
        .running(running),
        .done   (done),
        .expired(expired)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("[TB] FAIL %s: got %0d expected %0d (cyc %0d)", name, act, req, cyc);
        end
    endtask

    task automatic push_exp(input int c, input logic [W-1:0] n, input logic e, input logic r, input logic d);
        event_t ev;
        ev.cyc = c; ev.cnt = n; ev.exp = e; ev.run = r; ev.dn = d;
        sb.push_back(ev);
    endtask

    // Called at a negedge: drives one cycle of pulses, returns at the next negedge.
    task automatic applyStimulus(input logic ld, input logic [W-1:0] pre, input logic st,
                                 input logic pa, output int issued);
        issued = cyc;
        load   = ld;
        preset = pre;
        start  = st;
        pause  = pa;
        if (ld) push_exp(cyc + 1, pre, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        load  = 1'b0;
        start = 1'b0;
        pause = 1'b0;
    endtask

    task automatic wait_until(input int target);
        while (cyc < target) @(negedge clk);
    endtask

    // Any count change or expired pulse is a DUT event that must match the next expectation.
    always @(negedge clk) begin
        if (mon_en) begin
            if ((count !== prev_count) || (expired === 1'b1)) begin
                if (sb.size() == 0) begin
                    total++;
                    bad++;
                    $display("[TB] FAIL unexpected_event: got count=%0d expired=%0b at cyc %0d, required none",
                             count, expired, cyc);
                end else begin
                    event_t ev;
                    ev = sb.pop_front();
                    checkOutput("event_cycle", cyc, ev.cyc);
                    checkOutput("event_count", count, ev.cnt);
                    checkOutput("event_expired", expired, ev.exp);
                    checkOutput("event_running", running, ev.run);
                    checkOutput("event_done", done, ev.dn);
                end
            end
            prev_count = count;
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int t;
        int s;

        repeat (2) @(posedge clk);
        @(negedge clk);
        checkOutput("reset_count", count, 0);
        checkOutput("reset_running", running, 0);
        checkOutput("reset_done", done, 0);
        checkOutput("reset_expired", expired, 0);
        rst        = 1'b0;
        prev_count = count;
        mon_en     = 1'b1;
        @(negedge clk);

        applyStimulus(1'b0, 8'd0, 1'b1, 1'b0, t);
        repeat (6) @(negedge clk);
        checkOutput("idle_start_zero_running", running, 0);
        checkOutput("idle_start_zero_count", count, 0);

`ifdef COUNTDOWN_AUTORELOAD_EN
        applyStimulus(1'b1, 8'd2, 1'b0, 1'b0, t);
        applyStimulus(1'b0, 8'd0, 1'b1, 1'b0, s);
        push_exp(s + 5,  8'd1, 1'b0, 1'b1, 1'b0);
        push_exp(s + 9,  8'd2, 1'b1, 1'b1, 1'b0);
        push_exp(s + 13, 8'd1, 1'b0, 1'b1, 1'b0);
        push_exp(s + 17, 8'd2, 1'b1, 1'b1, 1'b0);
        while (cyc < s + 18) begin
            checkOutput("reload_running", running, 1);
            checkOutput("reload_done", done, 0);
            @(negedge clk);
        end
`else
        // Full countdown from 3.
        applyStimulus(1'b1, 8'd3, 1'b0, 1'b0, t);
        applyStimulus(1'b0, 8'd0, 1'b1, 1'b0, s);
        checkOutput("run_after_start", running, 1);
        push_exp(s + 5,  8'd2, 1'b0, 1'b1, 1'b0);
        push_exp(s + 9,  8'd1, 1'b0, 1'b1, 1'b0);
        push_exp(s + 13, 8'd0, 1'b1, 1'b0, 1'b1);
        wait_until(s + 14);
        checkOutput("done_after_expiry", done, 1);
        checkOutput("running_after_expiry", running, 0);
        checkOutput("expired_one_cycle", expired, 0);
        applyStimulus(1'b0, 8'd0, 1'b1, 1'b0, t);
        applyStimulus(1'b0, 8'd0, 1'b0, 1'b1, t);
        checkOutput("done_ignores_start_pause", done, 1);
        checkOutput("done_count_zero", count, 0);

        // Pause mid-count and resume the partial second.
        applyStimulus(1'b1, 8'd10, 1'b0, 1'b0, t);
        checkOutput("load_clears_done", done, 0);
        applyStimulus(1'b0, 8'd0, 1'b1, 1'b0, s);
        push_exp(s + 5, 8'd9, 1'b0, 1'b1, 1'b0);
        push_exp(s + 9, 8'd8, 1'b0, 1'b1, 1'b0);
        wait_until(s + 10);
        applyStimulus(1'b0, 8'd0, 1'b0, 1'b1, t);
        for (int i = 0; i < 20; i++) begin
            checkOutput("pause_hold_count", count, 8);
            checkOutput("pause_running", running, 0);
            @(negedge clk);
        end
        applyStimulus(1'b0, 8'd0, 1'b1, 1'b0, s);
        push_exp(s + 3,  8'd7, 1'b0, 1'b1, 1'b0);
        push_exp(s + 7,  8'd6, 1'b0, 1'b1, 1'b0);
        push_exp(s + 11, 8'd5, 1'b0, 1'b1, 1'b0);

        // Load during RUN restarts the prescaler.
        wait_until(s + 12);
        applyStimulus(1'b1, 8'd255, 1'b0, 1'b0, t);
        checkOutput("load_in_run_idle", running, 0);
        applyStimulus(1'b0, 8'd0, 1'b1, 1'b0, s);
        push_exp(s + 5, 8'd254, 1'b0, 1'b1, 1'b0);
        wait_until(s + 6);

        // Pause coinciding with the final tick still lands in DONE.
        applyStimulus(1'b1, 8'd2, 1'b0, 1'b0, t);
        applyStimulus(1'b0, 8'd0, 1'b1, 1'b0, s);
        push_exp(s + 5, 8'd1, 1'b0, 1'b1, 1'b0);
        push_exp(s + 9, 8'd0, 1'b1, 1'b0, 1'b1);
        wait_until(s + 8);
        applyStimulus(1'b0, 8'd0, 1'b0, 1'b1, t);
        checkOutput("coincide_done", done, 1);
        checkOutput("coincide_not_paused", running, 0);
        @(negedge clk);
        checkOutput("coincide_expired_cleared", expired, 0);

        applyStimulus(1'b1, 8'd2, 1'b0, 1'b0, t);
        checkOutput("load_in_done_done", done, 0);
        checkOutput("load_in_done_running", running, 0);
`endif

        repeat (3) @(negedge clk);
        checkOutput("scoreboard_drained", sb.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
